// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - 16:4 round-robin request encoder with pending set and valid/ready output
// Captures request pulses into a pending set and emits them one at a time as binary indices.

module request_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] in,
  input  logic        ready,
  output logic [3:0]  out,
  output logic        valid,
  output logic [15:0] pending,
  output logic        overflow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  out_q, out_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        overflow_q, overflow_d;

  logic        load;
  logic [15:0] grant_mask;
  logic [15:0] captured;
  logic [31:0] doubled;
  logic [15:0] rotated;
  logic [3:0]  offset;
  logic [3:0]  winner;
  logic        found;

  // Rotate pending so bit 0 is the line at ptr; the first set bit is then the winner's distance.
  always_comb begin
    doubled = {pending_q, pending_q} >> ptr_q;
    rotated = doubled[15:0];
    offset  = 4'd0;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && rotated[i]) begin
        offset = 4'(i);
        found  = 1'b1;
      end
    end
    winner = ptr_q + offset;
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    ptr_d      = ptr_q;
    grant_mask = 16'h0000;
    load       = ((state_q == EMPTY) || ready) && (|pending_q);
    captured   = enable ? in : 16'h0000;

    if (load) begin
      state_d    = FULL;
      out_d      = winner;
      ptr_d      = winner + 4'd1;
      grant_mask = 16'h0001 << winner;
    end else if ((state_q == FULL) && ready) begin
      state_d = EMPTY;
    end

    // A re-raise of the line being granted this edge survives the clear and is not a duplicate.
    pending_d  = (pending_q & ~grant_mask) | captured;
    overflow_d = overflow_q | (|(captured & pending_q & ~grant_mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      pending_q  <= 16'h0000;
      out_q      <= 4'd0;
      ptr_q      <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign valid    = (state_q == FULL);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_request_encoder.sv
// tb/tb_request_encoder.sv - directed self-checking bench for request_encoder

module tb_request_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] in;
  logic        ready;
  logic [3:0]  out;
  logic        valid;
  logic [15:0] pending;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  request_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in       (in),
    .ready    (ready),
    .out      (out),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    in     = 16'h0000;
    ready  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    in     = 16'hFFFF;
    ready  = 1'b1;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passes++;
    checks++; if (out !== 4'd0) $display("FAIL reset_out got=%0d exp=0", out); else passes++;
    checks++; if (pending !== 16'h0000) $display("FAIL reset_pending got=%h exp=0000", pending); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passes++;
    reset  = 1'b0;
    enable = 1'b0;
    in     = 16'h0000;
  endtask

  task automatic test_single();
    do_reset();
    ready  = 1'b1;
    enable = 1'b1;
    in     = 16'h0020;
    step();
    enable = 1'b0;
    in     = 16'h0000;
    checks++; if (pending !== 16'h0020) $display("FAIL single_pending got=%h exp=0020", pending); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", valid); else passes++;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd5) $display("FAIL single_out got=%b/%0d exp=1/5", valid, out); else passes++;
    checks++; if (pending !== 16'h0000) $display("FAIL single_pending_clr got=%h exp=0000", pending); else passes++;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", valid); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL single_overflow got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd0, 4'd5, 4'd10, 4'd15};
    do_reset();
    ready  = 1'b1;
    enable = 1'b1;
    in     = 16'h8421;
    step();
    in = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (valid !== 1'b1 || out !== exp_seq[i]) $display("FAIL rr_burst%0d got=%b/%0d exp=1/%0d", i, valid, out, exp_seq[i]); else passes++;
    end
    in = 16'h0003;
    step();
    in     = 16'h0000;
    enable = 1'b0;
    checks++; if (valid !== 1'b0) $display("FAIL rr_gap got=%b exp=0", valid); else passes++;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd0) $display("FAIL rr_wrap0 got=%b/%0d exp=1/0", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd1) $display("FAIL rr_wrap1 got=%b/%0d exp=1/1", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL rr_end got=%b exp=0", valid); else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready  = 1'b0;
    enable = 1'b1;
    in     = 16'h0006;
    step();
    enable = 1'b0;
    in     = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (valid !== 1'b1 || out !== 4'd1) $display("FAIL bp_hold%0d got=%b/%0d exp=1/1", i, valid, out); else passes++;
    end
    checks++; if (pending !== 16'h0004) $display("FAIL bp_pending got=%h exp=0004", pending); else passes++;
    ready = 1'b1;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd2) $display("FAIL bp_next got=%b/%0d exp=1/2", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL bp_end got=%b exp=0", valid); else passes++;
  endtask

  task automatic test_overflow();
    int count3;
    do_reset();
    ready  = 1'b0;
    enable = 1'b1;
    in     = 16'h0001;
    step();
    in = 16'h0008;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd0) $display("FAIL ov_blocker got=%b/%0d exp=1/0", valid, out); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL ov_early got=%b exp=0", overflow); else passes++;
    step();
    enable = 1'b0;
    in     = 16'h0000;
    checks++; if (overflow !== 1'b1) $display("FAIL ov_set got=%b exp=1", overflow); else passes++;
    checks++; if (pending !== 16'h0008) $display("FAIL ov_pending got=%h exp=0008", pending); else passes++;
    ready  = 1'b1;
    count3 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid === 1'b1 && out === 4'd3) count3++;
    end
    checks++; if (count3 != 1) $display("FAIL ov_emit_once got=%0d exp=1", count3); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ov_sticky got=%b exp=1", overflow); else passes++;
  endtask

  task automatic test_set_wins();
    do_reset();
    ready  = 1'b1;
    enable = 1'b1;
    in     = 16'h0010;
    step();
    step();
    enable = 1'b0;
    in     = 16'h0000;
    checks++; if (valid !== 1'b1 || out !== 4'd4) $display("FAIL sw_first got=%b/%0d exp=1/4", valid, out); else passes++;
    checks++; if (pending !== 16'h0010) $display("FAIL sw_pending got=%h exp=0010", pending); else passes++;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd4) $display("FAIL sw_second got=%b/%0d exp=1/4", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL sw_end got=%b exp=0", valid); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL sw_overflow got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_enable_gating();
    do_reset();
    ready  = 1'b1;
    enable = 1'b0;
    in     = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pending !== 16'h0000 || valid !== 1'b0) $display("FAIL en_gate%0d got=%h/%b exp=0000/0", i, pending, valid); else passes++;
    end
    in = 16'h0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ready  = 1'b1;
    enable = 1'b1;
    in     = 16'hFFFF;
    step();
    enable = 1'b0;
    in     = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (valid !== 1'b1 || out !== 4'(i)) $display("FAIL rm_burst%0d got=%b/%0d exp=1/%0d", i, valid, out, i); else passes++;
    end
    reset  = 1'b1;
    enable = 1'b1;
    in     = 16'h0100;
    step();
    reset  = 1'b0;
    checks++; if (valid !== 1'b0 || pending !== 16'h0000) $display("FAIL rm_cleared got=%b/%h exp=0/0000", valid, pending); else passes++;
    in = 16'h8001;
    step();
    enable = 1'b0;
    in     = 16'h0000;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd0) $display("FAIL rm_after0 got=%b/%0d exp=1/0", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b1 || out !== 4'd15) $display("FAIL rm_after15 got=%b/%0d exp=1/15", valid, out); else passes++;
    step();
    checks++; if (valid !== 1'b0) $display("FAIL rm_end got=%b exp=0", valid); else passes++;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    in     = 16'h0000;
    ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_set_wins();
    test_enable_gating();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
